// File: rtl/datapath_controller.sv
// Four-state instruction sequencer for regfile_alu_datapath: captures one CR16-style word,
// decodes it into datapath selects, strobes the regfile write in EXECUTE and pulses done.
module datapath_controller #(
  parameter int IMM_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  regA,
  output logic [3:0]  regB,
  output logic [3:0]  write_select,
  output logic        write_enable,
  output logic [7:0]  op,
  output logic        reg_imm,
  output logic [15:0] immediate_value,
  output logic        reg_reset,
  output logic        external_write_enable,
  output logic        external_encoder_enable
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, DONE} state_t;

  localparam logic [3:0] OPC_RTYPE = 4'b0000;
  localparam logic [3:0] OPC_ANDI  = 4'b0001;
  localparam logic [3:0] OPC_ORI   = 4'b0010;
  localparam logic [3:0] OPC_XORI  = 4'b0011;
  localparam logic [3:0] OPC_UND0  = 4'b0100;
  localparam logic [3:0] OPC_SHIFT = 4'b1000;
  localparam logic [3:0] OPC_CMPI  = 4'b1011;
  localparam logic [3:0] OPC_UND1  = 4'b1100;
  localparam logic [3:0] OPC_LUI   = 4'b1111;
  localparam logic [3:0] EXT_CMP   = 4'b1011;

  state_t state, stateNext;

  logic        capture;
  logic        readyNext, doneNext, weNext, illegalNext;
  logic        irWrites, irIllegal;

  logic [3:0]  opc, ext;
  logic [7:0]  decOp;
  logic        decRegImm, decWrites, decIllegal;
  logic [15:0] decImm;

  assign opc = instr[15:12];
  assign ext = instr[7:4];

  // Decoding straight from the incoming word lets the selects be valid during DECODE itself.
  always_comb begin
    decOp      = '0;
    decRegImm  = 1'b0;
    decImm     = '0;
    decWrites  = 1'b0;
    decIllegal = 1'b0;
    case (opc)
      OPC_RTYPE: begin
        decOp     = {4'b0000, ext};
        decWrites = (ext != EXT_CMP);
      end
      OPC_SHIFT: begin
        decOp     = {OPC_SHIFT, ext};
        decWrites = 1'b1;
        if (ext[3:1] == 3'b000) begin
          decRegImm = 1'b1;
          decImm    = {12'h000, instr[3:0]};
        end
      end
      OPC_UND0, OPC_UND1: begin
        decIllegal = 1'b1;
      end
      default: begin
        decOp     = {opc, 4'b0000};
        decRegImm = 1'b1;
        decWrites = (opc != OPC_CMPI);
        case (opc)
          OPC_ANDI, OPC_ORI, OPC_XORI:
            decImm = {{(16-IMM_W){1'b0}}, instr[IMM_W-1:0]};
          OPC_LUI:
            decImm = {instr[IMM_W-1:0], {(16-IMM_W){1'b0}}};
          default:
            decImm = {{(16-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
        endcase
      end
    endcase
  end

  // Output flags are derived from the next state so every output comes straight off a flop.
  always_comb begin
    stateNext   = state;
    capture     = 1'b0;
    readyNext   = 1'b0;
    doneNext    = 1'b0;
    weNext      = 1'b0;
    illegalNext = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          stateNext = DECODE;
          capture   = 1'b1;
        end
      end
      DECODE:  stateNext = EXECUTE;
      EXECUTE: stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    readyNext   = (stateNext == IDLE);
    weNext      = (stateNext == EXECUTE) && irWrites;
    doneNext    = (stateNext == DONE);
    illegalNext = doneNext && irIllegal;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      instr_ready     <= 1'b1;
      done            <= 1'b0;
      illegal         <= 1'b0;
      write_enable    <= 1'b0;
      reg_reset       <= 1'b1;
      regA            <= '0;
      regB            <= '0;
      write_select    <= '0;
      op              <= '0;
      reg_imm         <= 1'b0;
      immediate_value <= '0;
      irWrites        <= 1'b0;
      irIllegal       <= 1'b0;
    end else begin
      state        <= stateNext;
      instr_ready  <= readyNext;
      done         <= doneNext;
      illegal      <= illegalNext;
      write_enable <= weNext;
      reg_reset    <= 1'b0;
      if (capture) begin
        regA            <= instr[11:8];
        regB            <= instr[3:0];
        write_select    <= instr[11:8];
        op              <= decOp;
        reg_imm         <= decRegImm;
        immediate_value <= decImm;
        irWrites        <= decWrites;
        irIllegal       <= decIllegal;
      end
    end
  end

  assign external_write_enable   = 1'b0;
  assign external_encoder_enable = 1'b0;

endmodule
